// File: rtl/cache_mem_arbiter.sv
// Memory-side arbiter for per-core icache/dcache requesters sharing one word-wide RAM port.
// Data requests outrank fetches; a dcache keeps its grant for up to BLK_WORDS words.
module cache_mem_arbiter #(
  parameter int CPUS      = 2,
  parameter int BLK_WORDS = 2
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [CPUS-1:0]       iREN,
  input  logic [CPUS-1:0][31:0] iaddr,
  output logic [CPUS-1:0]       iwait,
  output logic [CPUS-1:0][31:0] iload,
  input  logic [CPUS-1:0]       dREN,
  input  logic [CPUS-1:0]       dWEN,
  input  logic [CPUS-1:0][31:0] daddr,
  input  logic [CPUS-1:0][31:0] dstore,
  output logic [CPUS-1:0]       dwait,
  output logic [CPUS-1:0][31:0] dload,
  output logic                  ramREN,
  output logic                  ramWEN,
  output logic [31:0]           ramaddr,
  output logic [31:0]           ramstore,
  input  logic [31:0]           ramload,
  input  logic [1:0]            ramstate
);

  localparam int OW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int CW = $clog2(BLK_WORDS) + 1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [1:0] {IDLE, GRANT_D, GRANT_I} state_t;

  state_t        state;
  logic [OW-1:0] owner;
  logic [OW-1:0] rr;
  logic [CW-1:0] wcnt;

  // Handshake: a requester holds REN/WEN (with address/data stable) until it
  // sees its wait low; wait low marks the single cycle the word completes.
  logic          access;
  logic          own_dren;
  logic          own_dwen;
  logic          own_iren;
  logic          own_dreq;

  assign access   = (ramstate == RAM_ACCESS);
  assign own_dren = dREN[owner];
  assign own_dwen = dWEN[owner];
  assign own_iren = iREN[owner];
  assign own_dreq = own_dren | own_dwen;

  logic          d_found;
  logic          i_found;
  logic [OW-1:0] d_pick;
  logic [OW-1:0] i_pick;

  // Round-robin search starts just past the last core served.
  always_comb begin
    int idx;
    idx     = 0;
    d_found = 1'b0;
    i_found = 1'b0;
    d_pick  = '0;
    i_pick  = '0;
    for (int k = 1; k <= CPUS; k++) begin
      idx = (int'(rr) + k) % CPUS;
      if (!d_found && (dREN[idx] || dWEN[idx])) begin
        d_found = 1'b1;
        d_pick  = idx[OW-1:0];
      end
      if (!i_found && iREN[idx]) begin
        i_found = 1'b1;
        i_pick  = idx[OW-1:0];
      end
    end
  end

  always_comb begin
    iwait    = '1;
    iload    = '0;
    dwait    = '1;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      GRANT_D: begin
        ramaddr  = daddr[owner];
        ramstore = dstore[owner];
        ramWEN   = own_dwen;
        ramREN   = own_dren & ~own_dwen;
        if (access && own_dreq) begin
          dwait[owner] = 1'b0;
          if (!own_dwen) dload[owner] = ramload;
        end
      end
      GRANT_I: begin
        ramaddr = iaddr[owner];
        ramREN  = own_iren;
        if (access && own_iren) begin
          iwait[owner] = 1'b0;
          iload[owner] = ramload;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      owner <= '0;
      wcnt  <= '0;
      rr    <= OW'(CPUS - 1);
    end else begin
      case (state)
        IDLE: begin
          if (d_found) begin
            owner <= d_pick;
            wcnt  <= '0;
            state <= GRANT_D;
          end else if (i_found) begin
            owner <= i_pick;
            wcnt  <= '0;
            state <= GRANT_I;
          end
        end
        GRANT_D: begin
          // A dropped request releases the grant; wcnt keeps the words done.
          if (!own_dreq) begin
            state <= IDLE;
            rr    <= owner;
          end else if (access) begin
            wcnt <= wcnt + 1'b1;
            if (wcnt == CW'(BLK_WORDS - 1)) begin
              state <= IDLE;
              rr    <= owner;
            end
          end
        end
        GRANT_I: begin
          if (!own_iren || access) begin
            state <= IDLE;
            rr    <= owner;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: cycle vectors for arbitration patterns, hand sequences
// for writeback/load, halt store and mid-grant reset, plus a RAM transaction scoreboard.
module tb_cache_mem_arbiter;

  localparam int CPUS = 2;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2;
  localparam logic [31:0] RL = 32'hDEADBEEF;

  logic                  CLK;
  logic                  nRST;
  logic [CPUS-1:0]       iREN;
  logic [CPUS-1:0][31:0] iaddr;
  logic [CPUS-1:0]       iwait;
  logic [CPUS-1:0][31:0] iload;
  logic [CPUS-1:0]       dREN;
  logic [CPUS-1:0]       dWEN;
  logic [CPUS-1:0][31:0] daddr;
  logic [CPUS-1:0][31:0] dstore;
  logic [CPUS-1:0]       dwait;
  logic [CPUS-1:0][31:0] dload;
  logic                  ramREN;
  logic                  ramWEN;
  logic [31:0]           ramaddr;
  logic [31:0]           ramstore;
  logic [31:0]           ramload;
  logic [1:0]            ramstate;

  cache_mem_arbiter #(.CPUS(CPUS), .BLK_WORDS(2)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  logic [64:0] exp_q[$];
  logic [64:0] mon_act;
  logic [64:0] mon_exp;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_txn(input logic we, input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({we, a, d});
  endtask

  // scoreboard: every completed RAM word must match the next expected transaction
  always @(negedge CLK) begin
    if (nRST && ramstate == ACC && (ramREN || ramWEN)) begin
      mon_act = {ramWEN, ramaddr, ramWEN ? ramstore : (dload[0] | dload[1] | iload[0] | iload[1])};
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_unexpected: got %0h expected none", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("scoreboard_txn", mon_act, mon_exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  typedef struct {
    logic [1:0]  iren;
    logic [1:0]  dren;
    logic [1:0]  dwen;
    logic [31:0] da0;
    logic [1:0]  rs;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [1:0]  iw;
    logic [1:0]  dw;
  } vec_t;

  vec_t tbl[$];
  logic [31:0] exp_ld;

  initial begin
    // single-core read burst with BUSY wait states
    tbl.push_back(vec_t'{2'b00, 2'b01, 2'b00, 32'h100, FREE, 1'b0, 1'b0, 32'h0,    2'b11, 2'b11});
    tbl.push_back(vec_t'{2'b00, 2'b01, 2'b00, 32'h100, BUSY, 1'b1, 1'b0, 32'h100,  2'b11, 2'b11});
    tbl.push_back(vec_t'{2'b00, 2'b01, 2'b00, 32'h100, BUSY, 1'b1, 1'b0, 32'h100,  2'b11, 2'b11});
    tbl.push_back(vec_t'{2'b00, 2'b01, 2'b00, 32'h100, ACC,  1'b1, 1'b0, 32'h100,  2'b11, 2'b10});
    tbl.push_back(vec_t'{2'b00, 2'b01, 2'b00, 32'h104, BUSY, 1'b1, 1'b0, 32'h104,  2'b11, 2'b11});
    tbl.push_back(vec_t'{2'b00, 2'b01, 2'b00, 32'h104, ACC,  1'b1, 1'b0, 32'h104,  2'b11, 2'b10});
    tbl.push_back(vec_t'{2'b00, 2'b00, 2'b00, 32'h0,   FREE, 1'b0, 1'b0, 32'h0,    2'b11, 2'b11});
    // core 0 fetch vs core 1 write burst: data class wins
    tbl.push_back(vec_t'{2'b01, 2'b00, 2'b10, 32'h0,   FREE, 1'b0, 1'b0, 32'h0,    2'b11, 2'b11});
    tbl.push_back(vec_t'{2'b01, 2'b00, 2'b10, 32'h0,   ACC,  1'b0, 1'b1, 32'h400,  2'b11, 2'b01});
    tbl.push_back(vec_t'{2'b01, 2'b00, 2'b10, 32'h0,   BUSY, 1'b0, 1'b1, 32'h400,  2'b11, 2'b11});
    tbl.push_back(vec_t'{2'b01, 2'b00, 2'b10, 32'h0,   ACC,  1'b0, 1'b1, 32'h400,  2'b11, 2'b01});
    tbl.push_back(vec_t'{2'b01, 2'b00, 2'b00, 32'h0,   FREE, 1'b0, 1'b0, 32'h0,    2'b11, 2'b11});
    tbl.push_back(vec_t'{2'b01, 2'b00, 2'b00, 32'h0,   ACC,  1'b1, 1'b0, 32'h1000, 2'b10, 2'b11});
    tbl.push_back(vec_t'{2'b00, 2'b00, 2'b00, 32'h0,   FREE, 1'b0, 1'b0, 32'h0,    2'b11, 2'b11});
    // both cores fetching with immediate ACCESS alternate grants
    tbl.push_back(vec_t'{2'b11, 2'b00, 2'b00, 32'h0,   ACC,  1'b0, 1'b0, 32'h0,    2'b11, 2'b11});
    tbl.push_back(vec_t'{2'b11, 2'b00, 2'b00, 32'h0,   ACC,  1'b1, 1'b0, 32'h2000, 2'b01, 2'b11});
    tbl.push_back(vec_t'{2'b11, 2'b00, 2'b00, 32'h0,   ACC,  1'b0, 1'b0, 32'h0,    2'b11, 2'b11});
    tbl.push_back(vec_t'{2'b11, 2'b00, 2'b00, 32'h0,   ACC,  1'b1, 1'b0, 32'h1000, 2'b10, 2'b11});
    tbl.push_back(vec_t'{2'b11, 2'b00, 2'b00, 32'h0,   ACC,  1'b0, 1'b0, 32'h0,    2'b11, 2'b11});
    tbl.push_back(vec_t'{2'b11, 2'b00, 2'b00, 32'h0,   ACC,  1'b1, 1'b0, 32'h2000, 2'b01, 2'b11});
    tbl.push_back(vec_t'{2'b00, 2'b00, 2'b00, 32'h0,   FREE, 1'b0, 1'b0, 32'h0,    2'b11, 2'b11});

    nRST = 1'b0;
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr[0] = 32'h1000; iaddr[1] = 32'h2000;
    daddr[0] = 32'h0;    daddr[1] = 32'h400;
    dstore[0] = 32'h11110000; dstore[1] = 32'h5555AAAA;
    ramload = RL; ramstate = FREE;

    @(negedge CLK);
    chk("rst_iwait", iwait, 2'b11);
    chk("rst_dwait", dwait, 2'b11);
    chk("rst_strobes", {ramREN, ramWEN}, 2'b00);
    chk("rst_ramaddr", ramaddr, 32'h0);
    chk("rst_ramstore", ramstore, 32'h0);
    chk("rst_loads", {iload, dload}, 128'h0);
    tick();
    tick();
    nRST = 1'b1;

    // transactions the table will complete, in order
    push_txn(1'b0, 32'h100, RL);
    push_txn(1'b0, 32'h104, RL);
    push_txn(1'b1, 32'h400, 32'h5555AAAA);
    push_txn(1'b1, 32'h400, 32'h5555AAAA);
    push_txn(1'b0, 32'h1000, RL);
    push_txn(1'b0, 32'h2000, RL);
    push_txn(1'b0, 32'h1000, RL);
    push_txn(1'b0, 32'h2000, RL);

    for (int v = 0; v < tbl.size(); v++) begin
      iREN = tbl[v].iren; dREN = tbl[v].dren; dWEN = tbl[v].dwen;
      daddr[0] = tbl[v].da0; ramstate = tbl[v].rs;
      @(negedge CLK);
      chk($sformatf("vec%0d_ramREN", v), ramREN, tbl[v].ren);
      chk($sformatf("vec%0d_ramWEN", v), ramWEN, tbl[v].wen);
      chk($sformatf("vec%0d_ramaddr", v), ramaddr, tbl[v].addr);
      chk($sformatf("vec%0d_iwait", v), iwait, tbl[v].iw);
      chk($sformatf("vec%0d_dwait", v), dwait, tbl[v].dw);
      for (int k = 0; k < CPUS; k++) begin
        exp_ld = (!tbl[v].dw[k] && tbl[v].dren[k] && !tbl[v].dwen[k]) ? RL : 32'h0;
        chk($sformatf("vec%0d_dload%0d", v, k), dload[k], exp_ld);
        exp_ld = (!tbl[v].iw[k]) ? RL : 32'h0;
        chk($sformatf("vec%0d_iload%0d", v, k), iload[k], exp_ld);
      end
      tick();
    end

    // writeback then load on core 0 while core 1 keeps fetching
    iREN = 2'b10; dWEN = 2'b01; dREN = 2'b00;
    daddr[0] = 32'h200; dstore[0] = 32'hA0A00001; ramstate = FREE;
    push_txn(1'b1, 32'h200, 32'hA0A00001);
    push_txn(1'b1, 32'h204, 32'hA0A00002);
    @(negedge CLK);
    chk("wb_idle_wen", ramWEN, 1'b0);
    tick();
    ramstate = ACC;
    @(negedge CLK);
    chk("wb0_wen", ramWEN, 1'b1);
    chk("wb0_addr", ramaddr, 32'h200);
    chk("wb0_waits", {iwait, dwait}, 4'b1110);
    tick();
    daddr[0] = 32'h204; dstore[0] = 32'hA0A00002;
    @(negedge CLK);
    chk("wb1_addr", {ramWEN, ramaddr}, {1'b1, 32'h204});
    chk("wb1_waits", {iwait, dwait}, 4'b1110);
    tick();
    dWEN = 2'b00; dREN = 2'b01; daddr[0] = 32'h300; ramload = 32'h30000000;
    push_txn(1'b0, 32'h300, 32'h30000000);
    @(negedge CLK);
    chk("ld_gap_strobes", {ramREN, ramWEN}, 2'b00);
    chk("ld_gap_waits", {iwait, dwait}, 4'b1111);
    tick();
    @(negedge CLK);
    chk("ld0_addr", {ramREN, ramaddr}, {1'b1, 32'h300});
    chk("ld0_dload", dload[0], 32'h30000000);
    chk("ld0_iwait", iwait, 2'b11);
    tick();
    daddr[0] = 32'h304; ramload = 32'h30000004;
    push_txn(1'b0, 32'h304, 32'h30000004);
    @(negedge CLK);
    chk("ld1_addr", {ramREN, ramaddr}, {1'b1, 32'h304});
    chk("ld1_waits", {iwait, dwait}, 4'b1110);
    tick();
    dREN = 2'b00; ramstate = FREE;
    @(negedge CLK);
    chk("ld_done_strobes", {ramREN, ramWEN}, 2'b00);
    tick();
    ramstate = ACC; ramload = 32'h2000ABCD;
    push_txn(1'b0, 32'h2000, 32'h2000ABCD);
    @(negedge CLK);
    chk("fetch1_addr", {ramREN, ramaddr}, {1'b1, 32'h2000});
    chk("fetch1_iwait", iwait, 2'b01);
    chk("fetch1_iload", iload[1], 32'h2000ABCD);
    tick();
    iREN = 2'b00; ramstate = FREE;
    @(negedge CLK);
    chk("fetch1_done", ramREN, 1'b0);
    tick();

    // single-word halt store, then requester drops
    dWEN = 2'b01; daddr[0] = 32'h3100; dstore[0] = 32'h2A;
    push_txn(1'b1, 32'h3100, 32'h2A);
    @(negedge CLK);
    chk("halt_idle_wen", ramWEN, 1'b0);
    tick();
    ramstate = ACC;
    @(negedge CLK);
    chk("halt_wen", {ramWEN, ramaddr, ramstore}, {1'b1, 32'h3100, 32'h2A});
    chk("halt_dwait", dwait, 2'b10);
    tick();
    dWEN = 2'b00; ramstate = FREE;
    @(negedge CLK);
    chk("halt_drop_strobes", {ramREN, ramWEN}, 2'b00);
    chk("halt_drop_dwait", dwait, 2'b11);
    tick();
    ramstate = ACC;
    @(negedge CLK);
    chk("halt_after_strobes", {ramREN, ramWEN}, 2'b00);
    chk("halt_wcnt", dut.wcnt, 2'd1);
    chk("halt_state_idle", int'(dut.state), 0);
    tick();

    // reset in the middle of a write grant
    dWEN = 2'b01; daddr[0] = 32'h500; dstore[0] = 32'h77; ramstate = BUSY;
    @(negedge CLK);
    chk("rst_pre_wen", ramWEN, 1'b0);
    tick();
    @(negedge CLK);
    chk("rst_grant_wen", ramWEN, 1'b1);
    #2;
    nRST = 1'b0;
    #1;
    chk("rst_async_wen", ramWEN, 1'b0);
    chk("rst_async_waits", {iwait, dwait}, 4'b1111);
    chk("rst_async_addr", ramaddr, 32'h0);
    dWEN = 2'b00;
    tick();
    tick();
    nRST = 1'b1;
    dREN = 2'b11; daddr[0] = 32'h600; daddr[1] = 32'h700;
    ramstate = ACC; ramload = 32'h66666666;
    push_txn(1'b0, 32'h600, 32'h66666666);
    @(negedge CLK);
    chk("post_rst_idle", {ramREN, ramWEN}, 2'b00);
    tick();
    @(negedge CLK);
    chk("post_rst_core0", {ramREN, ramaddr}, {1'b1, 32'h600});
    chk("post_rst_dwait", dwait, 2'b10);
    chk("post_rst_dload", dload[0], 32'h66666666);
    tick();
    dREN = 2'b00; ramstate = FREE;
    tick();
    tick();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
